// File: rtl/instruction_fetch.sv
// Fetch stage: sequences the fetch PC, issues single-word reads to program
// memory, holds each returned instruction for decode and applies PC
// redirects from execute, including redirects that land mid-request.
//
// Handshakes: mem_read/mem_address are held stable until a cycle with
// mem_ready=1 completes the request. instruction/instruction_pc are offered
// while instruction_valid=1 and are consumed in a cycle with
// instruction_accept=1. An accept seen while instruction_valid=0 has no effect.
module instruction_fetch #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic                     mem_read,
  input  logic                     mem_ready,
  input  logic [15:0]              mem_data,
  output logic [15:0]              instruction,
  output logic [ADDRESS_WIDTH-1:0] instruction_pc,
  output logic                     instruction_valid,
  input  logic                     instruction_accept,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [1:0]               state_debug
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] PC_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_WIDTH-1:0]   pending_pc_q, pending_pc_d;
  logic [15:0]                instruction_q, instruction_d;
  logic [ADDRESS_WIDTH-1:0]   instruction_pc_q, instruction_pc_d;
  logic                       instruction_valid_q, instruction_valid_d;

  // Next-state and datapath update for the fetch sequencer.
  always_comb begin
    state_d             = state_q;
    fetch_pc_d          = fetch_pc_q;
    pending_pc_d        = pending_pc_q;
    instruction_d       = instruction_q;
    instruction_pc_d    = instruction_pc_q;
    instruction_valid_d = instruction_valid_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) fetch_pc_d = redirect_pc;
      end
      FETCH: begin
        if (mem_ready) begin
          if (redirect) begin
            // Returned word belongs to the old path; drop it and refetch.
            fetch_pc_d = redirect_pc;
          end else begin
            instruction_d       = mem_data;
            instruction_pc_d    = fetch_pc_q;
            instruction_valid_d = 1'b1;
            fetch_pc_d          = fetch_pc_q + PC_ONE;
            state_d             = HOLD;
          end
        end else if (redirect) begin
          // Address must stay put until memory answers, so park the target.
          pending_pc_d = redirect_pc;
          state_d      = FLUSH;
        end
      end
      FLUSH: begin
        if (mem_ready) begin
          fetch_pc_d = redirect ? redirect_pc : pending_pc_q;
          state_d    = FETCH;
        end else if (redirect) begin
          pending_pc_d = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect) begin
          // Covers both retire-then-redirect and squash of the held word.
          instruction_valid_d = 1'b0;
          fetch_pc_d          = redirect_pc;
          state_d             = FETCH;
        end else if (instruction_accept) begin
          instruction_valid_d = 1'b0;
          state_d             = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= IDLE;
      fetch_pc_q          <= RESET_PC;
      pending_pc_q        <= RESET_PC;
      instruction_q       <= 16'h0000;
      instruction_pc_q    <= '0;
      instruction_valid_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      fetch_pc_q          <= fetch_pc_d;
      pending_pc_q        <= pending_pc_d;
      instruction_q       <= instruction_d;
      instruction_pc_q    <= instruction_pc_d;
      instruction_valid_q <= instruction_valid_d;
    end
  end

  assign mem_read          = (state_q == FETCH) || (state_q == FLUSH);
  assign mem_address       = fetch_pc_q;
  assign instruction       = instruction_q;
  assign instruction_pc    = instruction_pc_q;
  assign instruction_valid = instruction_valid_q;
  assign state_debug       = state_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Sequences the fetch PC and issues single-word reads to program memory.
- Captures each 16-bit instruction into a holding register and presents it, with its PC, to decode/execute under a valid/accept handshake.
- Applies PC redirects from execute (instructions whose destination is PC), including redirects that arrive while a memory read is outstanding.

Parameters:
- ADDRESS_WIDTH, 16, width of the program memory word address and of all PC values.
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clock  input  1  single clock for the block; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_address  output  ADDRESS_WIDTH  word address of the current read.
- mem_read  output  1  read request; held with a stable address until mem_ready.
- mem_ready  input  1  mem_data is valid this cycle and the request completes.
- mem_data  input  16  instruction word returned by memory.
- instruction  output  16  held instruction word, fed to the decoder.
- instruction_pc  output  ADDRESS_WIDTH  address the held instruction was fetched from.
- instruction_valid  output  1  instruction and instruction_pc are valid.
- instruction_accept  input  1  consumer takes the held instruction this cycle.
- redirect  input  1  execute writes the PC.
- redirect_pc  input  ADDRESS_WIDTH  new fetch address; sampled only when redirect=1.

Behaviour:
- Reset (the cycle reset=1 is sampled):
  - state=IDLE, fetch_pc=RESET_PC, pending_pc=RESET_PC.
  - instruction=16'h0000, instruction_pc=0, instruction_valid=0.
  - mem_read=0, mem_address=fetch_pc.
  - Reset overrides every other input, including mid-request. An outstanding memory response is not waited for; memory must tolerate request withdrawal on reset.
- IDLE: mem_read=0. Next cycle -> FETCH (one bubble after reset). A redirect in IDLE loads fetch_pc=redirect_pc.
- FETCH: mem_read=1, mem_address=fetch_pc.
  - mem_ready=1, redirect=0: instruction<=mem_data, instruction_pc<=fetch_pc, instruction_valid<=1, fetch_pc<=fetch_pc+1 -> HOLD.
  - mem_ready=1, redirect=1: discard data, fetch_pc<=redirect_pc, stay FETCH.
  - mem_ready=0, redirect=1: pending_pc<=redirect_pc -> FLUSH. The address is held until the request completes.
  - mem_ready=0, redirect=0: hold, no change.
- FLUSH: mem_read=1, mem_address=fetch_pc (the old address).
  - A further redirect overwrites pending_pc; the last redirect wins.
  - On mem_ready=1: data discarded, fetch_pc<=(redirect ? redirect_pc : pending_pc) -> FETCH.
- HOLD: mem_read=0, instruction_valid=1. Outputs are stable until accepted.
  - accept=1, redirect=0: instruction_valid<=0 -> FETCH at fetch_pc.
  - accept=1, redirect=1: the consumed instruction is retired, instruction_valid<=0, fetch_pc<=redirect_pc -> FETCH.
  - accept=0, redirect=1: held instruction squashed, instruction_valid<=0, fetch_pc<=redirect_pc -> FETCH.
  - accept=0, redirect=0: hold.
- instruction_accept while instruction_valid=0 is ignored.
- Latency and throughput:
  - mem_ready in cycle N -> instruction_valid=1 in cycle N+1.
  - Peak throughput is one instruction per 2 cycles with zero-wait memory.
- Arithmetic: fetch_pc+1 is modulo 2^ADDRESS_WIDTH; 16'hFFFF wraps to 16'h0000 with no flag.
- Encoding: state uses 2 bits; the unused encoding returns to IDLE.
- Outputs: instruction and instruction_pc retain their last value while invalid. Only instruction_valid qualifies them.
- Memory protocol invariant: while mem_read=1 and mem_ready=0, mem_address does not change. The bench asserts this every cycle.

Test Plan:
- Reset then zero-wait memory returning mem_data=addr^16'hA5A5 -> mem_read first high 1 cycle after reset release at address 0. With accept tied high, instruction_pc sequence is 0,1,2,3 every 2 cycles, each paired with its matching data.
- Memory with 3 wait states, accept held low for 4 cycles after valid -> instruction and instruction_pc stable throughout, mem_read=0 in HOLD. Next fetch is at pc+1 after accept.
- Redirect to 16'h0040 in the cycle the pc=5 request is outstanding (mem_ready=0) -> address stays 5 until ready, returned data discarded (valid stays 0). Next request at 16'h0040; second redirect to 16'h0080 during FLUSH wins instead.
- HOLD with instruction_pc=7: redirect to 16'h0010 with accept=0 -> valid drops next cycle, next request at 16'h0010. Same with accept=1 -> instruction retired once, next request at 16'h0010.
- Redirect to 16'hFFFF, accept each instruction -> instruction_pc sequence is FFFF then 0000.
- Assert reset during FLUSH and during HOLD -> next cycle valid=0, mem_read=0, state IDLE. First post-reset request is at RESET_PC.
